// File: rtl/rv_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for rv_fetch_queue.
// Master is the IF/ID environment and slave is the queue itself.
interface rv_fetch_queue_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned CNT_W  = 3
);
    logic              flush;
    logic              enq_valid;
    logic              enq_ready;
    logic [ADDR_W-1:0] enq_pc;
    logic [INST_W-1:0] enq_inst;
    logic              deq_valid;
    logic              deq_ready;
    logic [ADDR_W-1:0] deq_pc;
    logic [INST_W-1:0] deq_inst;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    modport master (
        output flush, enq_valid, enq_pc, enq_inst, deq_ready,
        input  enq_ready, deq_valid, deq_pc, deq_inst, count, full, empty
    );

    modport slave (
        input  flush, enq_valid, enq_pc, enq_inst, deq_ready,
        output enq_ready, deq_valid, deq_pc, deq_inst, count, full, empty
    );
endinterface

// File: rtl/rv_fetch_queue.sv
// Instruction fetch queue between IF and ID: DEPTH-entry {pc, inst} FIFO with
// branch flush and an optional same-cycle bypass when the queue is empty.
module rv_fetch_queue #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    rv_fetch_queue_if.slave    bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count_q;

    logic   full_c;
    logic   empty_c;
    logic   bypass_c;
    logic   enq_ready_c;
    logic   deq_valid_c;
    logic   enq_fire_c;
    logic   deq_fire_c;
    logic   wr_en_c;
    logic   rd_en_c;
    entry_t head_c;

    // Occupancy flags and handshake decisions
    always_comb begin
        full_c      = (count_q == CNT_W'(DEPTH));
        empty_c     = (count_q == '0);
        bypass_c    = BYPASS && empty_c && bus.enq_valid && !bus.flush;
        enq_ready_c = !full_c && !bus.flush;
        deq_valid_c = !rst && !bus.flush && (!empty_c || bypass_c);
        enq_fire_c  = bus.enq_valid && enq_ready_c;
        deq_fire_c  = deq_valid_c && bus.deq_ready;
        // A bypassed entry taken by decode in the same cycle is never stored
        wr_en_c     = enq_fire_c && !(bypass_c && bus.deq_ready);
        rd_en_c     = deq_fire_c && !empty_c;
    end

    // Head selection; invalid cycles present an all-zero bubble
    always_comb begin
        head_c = '0;
        if (deq_valid_c) begin
            if (empty_c) begin
                head_c.pc   = bus.enq_pc;
                head_c.inst = bus.enq_inst;
            end else begin
                head_c = mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en_c) rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_q + CNT_W'(wr_en_c) - CNT_W'(rd_en_c);
        end
    end

    // Storage carries no reset; contents are only read behind a valid count
    always_ff @(posedge clk) begin
        if (wr_en_c && !bus.flush) begin
            mem[wr_ptr] <= '{pc: bus.enq_pc, inst: bus.enq_inst};
        end
    end

    assign bus.enq_ready = enq_ready_c;
    assign bus.deq_valid = deq_valid_c;
    assign bus.deq_pc    = head_c.pc;
    assign bus.deq_inst  = head_c.inst;
    assign bus.count     = count_q;
    assign bus.full      = full_c;
    assign bus.empty     = empty_c;

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(DEPTH));
    a_no_write_when_full : assert property (@(posedge clk) disable iff (rst)
        !(wr_en_c && full_c));
    a_no_read_when_empty : assert property (@(posedge clk) disable iff (rst)
        !(rd_en_c && empty_c));
endmodule
